// File: rtl/ram_lane_sdp.sv
`default_nettype none
// ============================================================================
//  Module   : ram_lane_sdp
//  Purpose  : Simple dual-port RAM with a per-lane write mask, a registered
//             valid-qualified read port, a selectable read-during-write mode
//             and a self-clearing sequencer that zeroes every word after reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_lane_sdp #(
    parameter int dwidth   = 32,    // word width in bits
    parameter int awidth   = 4,     // address width, depth = 2**awidth
    parameter int lanes    = 4,     // write-mask granularity
    parameter int rdw_mode = 0      // 0 = read-old, 1 = write-first
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [lanes-1:0]    wmask,
    input  logic [awidth-1:0]   waddr,
    input  logic [dwidth-1:0]   d,
    input  logic                ren,
    input  logic [awidth-1:0]   raddr,
    output logic [dwidth-1:0]   q,
    output logic                qvalid,
    output logic                busy
);

    localparam int                c_depth     = 2 ** awidth;
    localparam int                c_lw        = dwidth / lanes;
    localparam logic [awidth-1:0] c_last_addr = {awidth{1'b1}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [awidth-1:0]   r_clr_addr;
    logic [dwidth-1:0]   r_mem [c_depth];
    logic [dwidth-1:0]   w_merged;
    logic [dwidth-1:0]   w_rdata;
    logic [dwidth-1:0]   r_q;
    logic                r_qvalid;
    logic                w_clr_we;
    logic                w_usr_we;
    logic                w_rd_en;

    // User traffic is only honoured once the clear sequence has finished.
    assign w_clr_we = (r_state == CLEAR);
    assign w_usr_we = (r_state == READY) && load;
    assign w_rd_en  = (r_state == READY) && ren;

    // State register; any reset edge restarts the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR:   if (r_clr_addr == c_last_addr) w_state_next = READY;
            READY:   w_state_next = READY;
            default: w_state_next = CLEAR;
        endcase
    end

    // Clear address counter; wraps back to 0 as the sequence completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clr_addr <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end

    // Post-write word at waddr: masked lanes from d, the rest from memory.
    always_comb begin
        w_merged = r_mem[waddr];
        for (int i = 0; i < lanes; i++) begin
            if (wmask[i]) begin
                w_merged[i*c_lw +: c_lw] = d[i*c_lw +: c_lw];
            end
        end
    end

    // Memory write port; the reset edge itself leaves contents untouched.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_we) begin
                r_mem[r_clr_addr] <= '0;
            end else if (w_usr_we) begin
                r_mem[waddr] <= w_merged;
            end
        end
    end

    // Read data source: write-first forwards the merged word on a collision.
    generate
        if (rdw_mode != 0) begin : g_write_first
            assign w_rdata = (load && (waddr == raddr)) ? w_merged : r_mem[raddr];
        end else begin : g_read_old
            assign w_rdata = r_mem[raddr];
        end
    endgenerate

    // Registered read output; q holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q      <= '0;
            r_qvalid <= 1'b0;
        end else if (w_rd_en) begin
            r_q      <= w_rdata;
            r_qvalid <= 1'b1;
        end else begin
            r_qvalid <= 1'b0;
        end
    end

    assign q      = r_q;
    assign qvalid = r_qvalid;
    assign busy   = (r_state == CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_ram_lane_sdp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_lane_sdp
//  Purpose  : Self-checking bench for ram_lane_sdp. Both read-during-write
//             builds run side by side against a behavioural memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_lane_sdp;

    localparam int c_dw    = 32;
    localparam int c_aw    = 4;
    localparam int c_lanes = 4;
    localparam int c_depth = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic [3:0]        wmask;
    logic [3:0]        waddr;
    logic [31:0]       d;
    logic              ren;
    logic [3:0]        raddr;
    logic [31:0]       q0, q1;
    logic              qv0, qv1, busy0, busy1;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [31:0] m_mem [c_depth];
    int          m_clear_left;
    logic [31:0] m_q_old, m_q_new;
    logic        m_qv;

    ram_lane_sdp #(.dwidth(c_dw), .awidth(c_aw), .lanes(c_lanes), .rdw_mode(0)) u_dut_old (
        .clk(clk), .rst_n(rst_n), .load(load), .wmask(wmask), .waddr(waddr), .d(d),
        .ren(ren), .raddr(raddr), .q(q0), .qvalid(qv0), .busy(busy0)
    );

    ram_lane_sdp #(.dwidth(c_dw), .awidth(c_aw), .lanes(c_lanes), .rdw_mode(1)) u_dut_new (
        .clk(clk), .rst_n(rst_n), .load(load), .wmask(wmask), .waddr(waddr), .d(d),
        .ren(ren), .raddr(raddr), .q(q1), .qvalid(qv1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    // One clock edge: advance the model with the inputs presented, then compare.
    task automatic step();
        logic [31:0] pre;
        @(posedge clk);
        if (!rst_n) begin
            m_clear_left = c_depth;
            m_q_old      = '0;
            m_q_new      = '0;
            m_qv         = 1'b0;
        end else if (m_clear_left > 0) begin
            m_mem[c_depth - m_clear_left] = '0;
            m_clear_left--;
            m_qv = 1'b0;
        end else begin
            pre = m_mem[raddr];
            if (load) m_mem[waddr] = merge(m_mem[waddr], d, wmask);
            if (ren) begin
                m_q_old = pre;
                m_q_new = m_mem[raddr];
                m_qv    = 1'b1;
            end else begin
                m_qv = 1'b0;
            end
        end
        #1;
        check("busy_old", {31'd0, busy0}, {31'd0, m_clear_left > 0});
        check("busy_new", {31'd0, busy1}, {31'd0, m_clear_left > 0});
        check("qv_old",   {31'd0, qv0},   {31'd0, m_qv});
        check("qv_new",   {31'd0, qv1},   {31'd0, m_qv});
        check("q_old",    q0, m_q_old);
        check("q_new",    q1, m_q_new);
    endtask

    task automatic idle();
        load = 1'b0; ren = 1'b0;
        step();
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] v, input logic [3:0] m);
        load = 1'b1; ren = 1'b0; waddr = a; d = v; wmask = m;
        step();
        load = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        load = 1'b0; ren = 1'b1; raddr = a;
        step();
        ren = 1'b0;
    endtask

    task automatic clear_and_count(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) cnt++;
            if (!busy0) break;
            step();
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; load = 1'b0; ren = 1'b0;
        wmask = '0; waddr = '0; raddr = '0; d = '0;
        m_clear_left = c_depth; m_q_old = '0; m_q_new = '0; m_qv = 1'b0;
        for (int i = 0; i < c_depth; i++) m_mem[i] = 'x;

        // 1. Clear sequence and read-back of zeros
        step(); step();
        check("rst_q", q0, 32'h0);
        rst_n = 1'b1;
        clear_and_count(cnt);
        check("busy_edges", cnt, 16);
        for (int a = 0; a < c_depth; a++) begin
            do_read(a[3:0]);
            check("clr_rd_q", q0, 32'h0);
            check("clr_rd_qv", {31'd0, qv0}, 32'd1);
        end

        // 2. Masked write
        do_write(4'd11, 32'h11223344, 4'b1111);
        do_write(4'd11, 32'hAABBCCDD, 4'b0101);
        do_read(4'd11);
        check("mask_q", q0, 32'h11BB33DD);

        // 3. Read latency / valid
        do_write(4'd3, 32'h0000_0333, 4'hF);
        do_write(4'd4, 32'h0000_0444, 4'hF);
        do_read(4'd3);
        check("lat_q3", q0, 32'h333);
        do_read(4'd4);
        check("lat_q4", q0, 32'h444);
        idle();
        check("lat_qv_idle", {31'd0, qv0}, 32'd0);
        check("lat_hold", q0, 32'h444);

        // 4. Read-during-write on the same address
        do_write(4'd5, 32'h1, 4'hF);
        load = 1'b1; ren = 1'b1; wmask = 4'hF; waddr = 4'd5; raddr = 4'd5; d = 32'h2;
        step();
        load = 1'b0; ren = 1'b0;
        check("rdw_old", q0, 32'h1);
        check("rdw_new", q1, 32'h2);

        // 5. Traffic while busy is ignored
        rst_n = 1'b0; step(); rst_n = 1'b1;
        load = 1'b1; ren = 1'b1; d = 32'hFFFFFFFF; waddr = 4'd2; raddr = 4'd2; wmask = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step();
            check("busy_qv", {31'd0, qv0}, 32'd0);
        end
        load = 1'b0; ren = 1'b0;
        do_read(4'd2);
        check("busy_wr_ignored", q0, 32'h0);

        // 6. Reset with a read in flight
        do_write(4'd7, 32'hDEADBEEF, 4'hF);
        ren = 1'b1; raddr = 4'd7; rst_n = 1'b0;
        step();
        rst_n = 1'b1; ren = 1'b0;
        check("mid_rst_q", q0, 32'h0);
        clear_and_count(cnt);
        check("mid_busy_edges", cnt, 16);
        for (int a = 0; a < c_depth; a++) begin
            do_read(a[3:0]);
            check("mid_rd_q", q0, 32'h0);
        end

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            load  = $urandom_range(0, 1);
            ren   = $urandom_range(0, 1);
            wmask = 4'($urandom_range(0, 15));
            waddr = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 2) == 0) ? waddr : 4'($urandom_range(0, 15));
            d     = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
